first_order_sigma_delta: RTL and testbench

First-order, single-bit sigma-delta modulator. It converts a signed 24-bit sample into a 1-bit stream whose ones-density tracks the input value. It is the stimulus generator that feeds the `sigma_delta_stream_A/B` inputs of the filter slice. It runs on the 20 MHz modulator clock `mod_clock`, independent of the 200 MHz slice clock.

---
 rtl/sigdel_pkg.sv | 11 +
 rtl/first_order_sigma_delta.sv | 55 +++++
 tb/tb_first_order_sigma_delta.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/sigdel_pkg.sv
// Shared sigma-delta constants and sample type, used by the modulator and the slice bench.
package sigdel_pkg;

  localparam int unsigned INPUT_WIDTH = 24;

  typedef logic signed [INPUT_WIDTH-1:0] sample_t;

  localparam sample_t FULL_POS = {1'b0, {(INPUT_WIDTH-1){1'b1}}};
  localparam sample_t FULL_NEG = {1'b1, {(INPUT_WIDTH-1){1'b0}}};

endpackage

// File: rtl/first_order_sigma_delta.sv
// First-order single-bit sigma-delta modulator: signed sample in, 1-bit stream out.
// Integrator clamps instead of wrapping so narrow ACC_WIDTH overrides stay stable.
module first_order_sigma_delta #(
  parameter int unsigned INPUT_WIDTH = sigdel_pkg::INPUT_WIDTH,
  parameter int unsigned ACC_WIDTH   = INPUT_WIDTH + 2
) (
  input  logic                          mod_clock,
  input  logic                          reset_n,
  input  logic signed [INPUT_WIDTH-1:0] input_sig,
  output logic                          output_sig
);

  // Sum is computed two bits wider than either operand so clamping sees the true value
  localparam int unsigned SUM_W = ((ACC_WIDTH > INPUT_WIDTH) ? ACC_WIDTH : INPUT_WIDTH) + 2;

  localparam logic signed [SUM_W-1:0] FB_POS =
    {{(SUM_W-INPUT_WIDTH+1){1'b0}}, {(INPUT_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] FB_NEG =
    {{(SUM_W-INPUT_WIDTH+1){1'b1}}, {(INPUT_WIDTH-1){1'b0}}};

  localparam logic signed [ACC_WIDTH-1:0] ACC_HI = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_LO = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [SUM_W-1:0]     SUM_HI = SUM_W'(ACC_HI);
  localparam logic signed [SUM_W-1:0]     SUM_LO = SUM_W'(ACC_LO);

  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic signed [SUM_W-1:0]     fb;
  logic signed [SUM_W-1:0]     sum;

  // Feedback, error integration and saturation
  always_comb begin
    fb  = output_sig ? FB_POS : FB_NEG;
    sum = SUM_W'(acc) + SUM_W'(input_sig) - fb;
    if (sum > SUM_HI) begin
      acc_next = ACC_HI;
    end else if (sum < SUM_LO) begin
      acc_next = ACC_LO;
    end else begin
      acc_next = ACC_WIDTH'(sum);
    end
  end

  // Integrator and comparator; a zero accumulator counts as non-negative
  always_ff @(posedge mod_clock or negedge reset_n) begin
    if (!reset_n) begin
      acc        <= '0;
      output_sig <= 1'b0;
    end else begin
      acc        <= acc_next;
      output_sig <= ~acc_next[ACC_WIDTH-1];
    end
  end

endmodule

// File: tb/tb_first_order_sigma_delta.sv
// Directed bench for first_order_sigma_delta: vector table plus density, reset and clamp sequences.
module tb_first_order_sigma_delta;
  import sigdel_pkg::*;

  logic    mod_clock = 1'b0;
  logic    reset_n;
  logic    sat_reset_n;
  logic    output_sig;
  logic    sat_out;
  sample_t input_sig;
  sample_t sat_in;

  int tests = 0;
  int fails = 0;

  always #5 mod_clock = ~mod_clock;

  first_order_sigma_delta dut (
    .mod_clock (mod_clock),
    .reset_n   (reset_n),
    .input_sig (input_sig),
    .output_sig(output_sig)
  );

  first_order_sigma_delta #(
    .INPUT_WIDTH(INPUT_WIDTH),
    .ACC_WIDTH  (INPUT_WIDTH)
  ) sat (
    .mod_clock (mod_clock),
    .reset_n   (sat_reset_n),
    .input_sig (sat_in),
    .output_sig(sat_out)
  );

  typedef struct {
    int in_val;
    int exp_out;
    int exp_acc;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Called at a negedge; glitches the input before settling, then waits one full cycle
  task automatic step(input int v);
    input_sig = sample_t'($urandom);
    #1 input_sig = sample_t'(v);
    @(posedge mod_clock);
    @(negedge mod_clock);
  endtask

  task automatic sat_step(input int v);
    sat_in = sample_t'(v);
    @(posedge mod_clock);
    @(negedge mod_clock);
  endtask

  task automatic restart();
    reset_n = 1'b0;
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int fp;
    int fn;
    int ones;
    int a0;
    int amin;
    int amax;
    fp = int'(FULL_POS);
    fn = int'(FULL_NEG);

    // Hand-computed trajectory from reset: {input, output after edge, acc after edge}
    vecs[0]  = '{0,        1, 8388608};
    vecs[1]  = '{0,        1, 1};
    vecs[2]  = '{0,        0, -8388606};
    vecs[3]  = '{0,        1, 2};
    vecs[4]  = '{8388607,  1, 2};
    vecs[5]  = '{-8388608, 0, -16777213};
    vecs[6]  = '{-8388608, 0, -16777213};
    vecs[7]  = '{8388607,  1, 2};
    vecs[8]  = '{4194304,  0, -4194301};
    vecs[9]  = '{4194304,  1, 8388611};
    vecs[10] = '{-4194304, 0, -4194300};
    vecs[11] = '{-4194304, 1, 4};
    vecs[12] = '{-1,       0, -8388604};
    vecs[13] = '{1,        1, 5};

    reset_n     = 1'b0;
    sat_reset_n = 1'b0;
    input_sig   = '0;
    sat_in      = '0;

    repeat (3) begin
      @(negedge mod_clock);
      input_sig = sample_t'($urandom);
      check("reset_out", int'(output_sig), 0);
      check("reset_acc", int'(dut.acc), 0);
    end

    @(negedge mod_clock);
    input_sig = '0;
    reset_n   = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step(vecs[i].in_val);
      check($sformatf("vec%0d_out", i), int'(output_sig), vecs[i].exp_out);
      check($sformatf("vec%0d_acc", i), int'(dut.acc), vecs[i].exp_acc);
    end

    // Asynchronous reset mid-cycle while the output is high
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_out", int'(output_sig), 0);
    check("async_reset_acc", int'(dut.acc), 0);

    @(negedge mod_clock);
    reset_n = 1'b1;
    ones = 0;
    for (int i = 0; i < 1000; i++) begin
      step(0);
      if (i == 0) check("zero_bit0", int'(output_sig), 1);
      if (i == 1) check("zero_bit1", int'(output_sig), 1);
      if (i == 2) check("zero_bit2", int'(output_sig), 0);
      ones += int'(output_sig);
    end
    check_range("zero_density", ones, 499, 501);

    restart();
    step(fp);
    check("pos_first", int'(output_sig), 1);
    a0 = int'(dut.acc);
    check("pos_first_acc", a0, 16777215);
    for (int i = 0; i < 20; i++) begin
      step(fp);
      check("pos_hold_out", int'(output_sig), 1);
      check("pos_hold_acc", int'(dut.acc), a0);
    end

    restart();
    step(fn);
    check("neg_tie", int'(output_sig), 1);
    for (int i = 0; i < 20; i++) begin
      step(fn);
      check("neg_hold_out", int'(output_sig), 0);
    end

    restart();
    ones = 0;
    for (int i = 0; i < 4096; i++) begin
      step(4194304);
      ones += int'(output_sig);
    end
    check_range("dc_plus_quarter", ones, 3071, 3073);

    restart();
    ones = 0;
    for (int i = 0; i < 4096; i++) begin
      step(-4194304);
      ones += int'(output_sig);
    end
    check_range("dc_minus_quarter", ones, 1023, 1025);

    // Step 0 -> full scale -> 0, tracking the accumulator excursion
    restart();
    amin = 0;
    amax = 0;
    for (int i = 0; i < 100; i++) step(0);
    for (int i = 0; i < 12; i++) begin
      step(fp);
      if (i >= 1) check("step_up_out", int'(output_sig), 1);
      if (int'(dut.acc) < amin) amin = int'(dut.acc);
      if (int'(dut.acc) > amax) amax = int'(dut.acc);
    end
    ones = 0;
    for (int i = 0; i < 18; i++) begin
      step(0);
      if (i >= 2) ones += int'(output_sig);
      if (int'(dut.acc) < amin) amin = int'(dut.acc);
      if (int'(dut.acc) > amax) amax = int'(dut.acc);
    end
    check_range("step_down_density", ones, 7, 9);
    check_range("step_acc_max", amax, 0, 16777215);
    check_range("step_acc_min", amin, -16777216, 0);

    // Narrow integrator: worst-case errors must clamp, not wrap
    sat_reset_n = 1'b1;
    sat_step(fn);
    check("sat_tie_out", int'(sat_out), 1);
    check("sat_tie_acc", int'(sat.acc), 0);
    sat_step(fn);
    check("sat_low_out", int'(sat_out), 0);
    check("sat_low_acc", int'(sat.acc), -8388608);
    sat_step(fp);
    check("sat_swing_out", int'(sat_out), 1);
    check("sat_swing_acc", int'(sat.acc), 8388607);
    sat_step(fp);
    check("sat_hold_acc", int'(sat.acc), 8388607);
    sat_reset_n = 1'b0;
    #1 sat_reset_n = 1'b1;
    sat_step(fp);
    check("sat_high_out", int'(sat_out), 1);
    check("sat_high_acc", int'(sat.acc), 8388607);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
